// File: rtl/trace_decode.sv
// Trace packet decoder: expands address/word/timestamp packets into absolute-time
// bus events and buffers them in a small synchronous FIFO with a sticky drop flag.
module trace_decode #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        mclk,
  input  logic        reset_n,
  input  logic        packet_strobe,
  input  logic [1:0]  packet_type,
  input  logic [22:0] packet_payload,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [1:0]  ev_kind,
  output logic [22:0] ev_addr,
  output logic [1:0]  ev_ublb,
  output logic [15:0] ev_data,
  output logic [31:0] ev_time,
  output logic        overflow,
  input  logic        clear_ovf
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] PKT_ADDR  = 2'b00;
  localparam logic [1:0] PKT_READ  = 2'b01;
  localparam logic [1:0] PKT_WRITE = 2'b10;
  localparam logic [1:0] PKT_TIME  = 2'b11;

  typedef struct packed {
    logic [1:0]  kind;
    logic [22:0] addr;
    logic [1:0]  ublb;
    logic [15:0] data;
    logic [31:0] stamp;
  } event_t;

  // Decoder state
  logic [31:0] time_acc_reg;
  logic [22:0] base_addr_reg;
  logic [22:0] word_idx_reg;

  // FIFO state
  event_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overflow_reg;

  // Packet field decode
  logic [31:0] ts5;
  logic [31:0] word_time;
  logic        is_addr;
  logic        is_word;
  logic        is_time;
  event_t      new_event;

  logic        push_req;
  logic        full;
  logic        pop;
  logic        push;
  logic        drop;

  assign ts5       = {27'd0, packet_payload[22:18]};
  assign word_time = time_acc_reg + ts5;
  assign is_addr   = packet_strobe && (packet_type == PKT_ADDR);
  assign is_word   = packet_strobe && ((packet_type == PKT_READ) || (packet_type == PKT_WRITE));
  assign is_time   = packet_strobe && (packet_type == PKT_TIME);

  always_comb begin
    new_event = '0;
    if (is_addr) begin
      new_event.kind  = PKT_ADDR;
      new_event.addr  = packet_payload;
      new_event.stamp = time_acc_reg;
    end else if (is_word) begin
      new_event.kind  = packet_type;
      new_event.addr  = base_addr_reg + word_idx_reg;
      new_event.ublb  = packet_payload[17:16];
      new_event.data  = packet_payload[15:0];
      new_event.stamp = word_time;
    end
  end

  // A pop only happens on a non-empty FIFO, so an empty FIFO never passes through.
  assign push_req = is_addr || is_word;
  assign full     = (count_reg == FULL_COUNT);
  assign pop      = ev_valid && ev_ready;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      time_acc_reg  <= '0;
      base_addr_reg <= '0;
      word_idx_reg  <= '0;
    end else if (is_addr) begin
      base_addr_reg <= packet_payload;
      word_idx_reg  <= '0;
    end else if (is_word) begin
      time_acc_reg  <= word_time;
      word_idx_reg  <= word_idx_reg + 23'd1;
    end else if (is_time) begin
      time_acc_reg  <= time_acc_reg + {9'd0, packet_payload};
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      // A fresh drop beats a concurrent clear.
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (clear_ovf) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (push) begin
      mem[wr_ptr_reg] <= new_event;
    end
  end

  event_t head;
  assign head     = mem[rd_ptr_reg];
  assign ev_valid = (count_reg != '0);
  assign ev_kind  = head.kind;
  assign ev_addr  = head.addr;
  assign ev_ublb  = head.ublb;
  assign ev_data  = head.data;
  assign ev_time  = head.stamp;
  assign overflow = overflow_reg;

endmodule

// File: doc/trace_decode.md
TRACE_DECODE -- requirements
Module: trace_decode

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of decoded-event entries buffered (power of two, 2..16).
REQ-002 mclk  input  1  single clock; all logic on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 packet_strobe  input  1  one trace packet presented this cycle.
REQ-005 packet_type  input  2  00 address, 01 read word, 10 write word, 11 timestamp.
REQ-006 packet_payload  input  23  address (type 00); {ts5[22:18], ublb[17:16], data[15:0]} (types 01/10); elapsed count (type 11).
REQ-007 ev_valid  output  1  decoded event available at FIFO head.
REQ-008 ev_ready  input  1  consumer accepts head event when ev_valid is high.
REQ-009 ev_kind  output  2  00 address, 01 read, 10 write.
REQ-010 ev_addr  output  23  word address of event.
REQ-011 ev_ublb  output  2  byte lanes (0 for address events).
REQ-012 ev_data  output  16  data word (0 for address events).
REQ-013 ev_time  output  32  absolute cycle time of event.
REQ-014 overflow  output  1  sticky: an event was dropped.
REQ-015 clear_ovf  input  1  synchronous clear of overflow.

Function
REQ-016 Decoder state: time_acc (32 b), base_addr (23 b), word_idx (23 b); updated only on cycles with packet_strobe high.
REQ-017 Type 00: base_addr <= payload, word_idx <= 0; push event {00, payload, 0, 0, time_acc}; time_acc unchanged.
REQ-018 Type 01/10: time_acc <= time_acc + ts5 (zero-extended); push event {type, base_addr + word_idx mod 2^23, ublb, data, time_acc + ts5}; word_idx <= word_idx + 1 mod 2^23.
REQ-019 Type 11: time_acc <= time_acc + payload (zero-extended); no event pushed.
REQ-020 time_acc wraps modulo 2^32 without flag.
REQ-021 Output path is a FIFO_DEPTH-entry synchronous FIFO; ev_* reflect the head entry; ev_kind/addr/ublb/data/time are don't-care when ev_valid is low.
REQ-022 Latency: packet pushed at cycle N into an empty FIFO drives ev_valid high at cycle N+1.
REQ-023 Pop occurs when ev_valid && ev_ready; next entry (if any) visible the following cycle.
REQ-024 Push when full with simultaneous pop: push accepted, occupancy unchanged.
REQ-025 Push when full without pop: event dropped, overflow <= 1, decoder state (REQ-017..019) still updated.
REQ-026 clear_ovf concurrent with a new drop: overflow stays 1 (set wins).
REQ-027 Push and pop on the same cycle with the FIFO empty: no pass-through; event appears next cycle.
REQ-028 packet_strobe low: no state change except FIFO pop and overflow clear.

Reset
REQ-029 On reset_n low, asynchronously: time_acc=0, base_addr=0, word_idx=0, FIFO empty, ev_valid=0, overflow=0.
REQ-030 Reset asserted mid-stream discards all buffered events; first packet after release decodes from zero state.
REQ-031 Reset deassertion is synchronised by the instantiating level; block needs no internal synchroniser.

Verification
REQ-032 Address 0x001000 then read packets ts5=3, ts5=1, data 0xBEEF/0x1234, ev_ready=1 -> events: addr 0x001000 t=0; read 0x001000 t=3 data 0xBEEF; read 0x001001 t=4 data 0x1234.
REQ-033 Timestamp payload 0x400000 then write ts5=31 ublb=01 -> single write event, ev_time=0x40001F, ublb=01.
REQ-034 ev_ready=0, FIFO_DEPTH+2 word packets -> ev_valid=1, FIFO_DEPTH entries retained in order, overflow=1; clear_ovf pulse -> overflow=0; draining yields the first FIFO_DEPTH events unchanged.
REQ-035 base_addr=0x7FFFFF, two words -> second event ev_addr=0x000000; time_acc=0xFFFFFFF0 plus timestamp 0x20 -> ev_time of next word = 0x10+ts5.
REQ-036 Full FIFO with push and pop same cycle -> no overflow, occupancy constant, order preserved.
REQ-037 reset_n pulsed low with 3 events buffered -> ev_valid=0 immediately; next address packet reports ev_time=0.
